// File: rtl/turtle_pkg.sv
// Shared encodings for the program-counter generator: pc_sel codes and FSM state codes.
package turtle_pkg;

  localparam int unsigned PC_SEL_W = 3;
  localparam int unsigned CAUSE_W  = 5;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_HOLD   = 3'd0,
    PC_SEL_SEQ    = 3'd1,
    PC_SEL_JAL    = 3'd2,
    PC_SEL_JALR   = 3'd3,
    PC_SEL_BRANCH = 3'd4,
    PC_SEL_TRAP   = 3'd5,
    PC_SEL_MEM    = 3'd6,
    PC_SEL_MRET   = 3'd7
  } pc_sel_e;

  typedef enum logic [STATE_W-1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_PEND = 2'd2
  } pcg_state_e;

  // Selects 2..7 all replace the sequential flow with a computed target.
  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel != PC_SEL_HOLD) && (sel != PC_SEL_SEQ);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target mux with vectored trap offset and alignment check.
module pc_target_calc
  import turtle_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned C_EXT = 0
) (
  input  logic [XLEN-1:0]     pc,
  input  logic [PC_SEL_W-1:0] pc_sel,
  input  logic                inst_len2,
  input  logic [XLEN-1:0]     alu_out,
  input  logic [XLEN-1:0]     inst_imm_j,
  input  logic [XLEN-1:0]     inst_imm_b,
  input  logic                take_branch,
  input  logic [XLEN-1:0]     csr_mtvec,
  input  logic                trap_int,
  input  logic [CAUSE_W-1:0]  trap_cause,
  input  logic [XLEN-1:0]     csr_mepc,
  input  logic [XLEN-1:0]     mem_dout,
  output logic [XLEN-1:0]     pc_seq_c,
  output logic [XLEN-1:0]     target_c,
  output logic                redirect_c,
  output logic                misalign_c
);

  pc_sel_e         sel;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] trap_base;
  logic            check_align;

  assign sel       = pc_sel_e'(pc_sel);
  assign step      = ((C_EXT != 0) && inst_len2) ? XLEN'(2) : XLEN'(4);
  assign pc_seq_c  = pc + step;
  assign trap_base = csr_mtvec & ~XLEN'(3);

  // Target mux; trap entry and not-taken branches are exempt from the alignment check.
  always_comb begin
    target_c    = pc_seq_c;
    check_align = 1'b0;
    redirect_c  = is_redirect(sel);
    case (sel)
      PC_SEL_JAL: begin
        target_c    = pc + inst_imm_j;
        check_align = 1'b1;
      end
      PC_SEL_JALR: begin
        target_c    = alu_out & ~XLEN'(1);
        check_align = 1'b1;
      end
      PC_SEL_BRANCH: begin
        target_c    = take_branch ? (pc + inst_imm_b) : pc_seq_c;
        check_align = take_branch;
      end
      PC_SEL_TRAP: begin
        if ((csr_mtvec[1:0] == 2'b01) && trap_int)
          target_c = trap_base + XLEN'({trap_cause, 2'b00});
        else
          target_c = trap_base;
      end
      PC_SEL_MEM: begin
        target_c    = mem_dout;
        check_align = 1'b1;
      end
      PC_SEL_MRET: begin
        target_c    = csr_mepc;
        check_align = 1'b1;
      end
      default: begin
        target_c    = pc_seq_c;
        check_align = 1'b0;
      end
    endcase
  end

  assign misalign_c = check_align &&
                      (target_c[0] || ((C_EXT == 0) && target_c[1]));

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/pending FSM, PC and pending-redirect registers, error reporting.
module pc_gen
  import turtle_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'('h4),
  parameter int unsigned     C_EXT     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_SEL_W-1:0] pc_sel,
  input  logic                inst_len2,
  input  logic [XLEN-1:0]     alu_out,
  input  logic [XLEN-1:0]     inst_imm_j,
  input  logic [XLEN-1:0]     inst_imm_b,
  input  logic                take_branch,
  input  logic [XLEN-1:0]     csr_mtvec,
  input  logic                trap_int,
  input  logic [CAUSE_W-1:0]  trap_cause,
  input  logic [XLEN-1:0]     csr_mepc,
  input  logic [XLEN-1:0]     mem_dout,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     pc_seq_out,
  output logic                misalign_err,
  output logic [XLEN-1:0]     misalign_addr
);

  pcg_state_e      state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] pc_d, addr_d;
  logic            err_d, fetch_valid_d;
  logic [XLEN-1:0] target_c, pc_seq_c;
  logic            redirect_c, misalign_c, accept_c, active_c;

  pc_target_calc #(.XLEN(XLEN), .C_EXT(C_EXT)) u_calc (
    .pc          (pc_out),
    .pc_sel      (pc_sel),
    .inst_len2   (inst_len2),
    .alu_out     (alu_out),
    .inst_imm_j  (inst_imm_j),
    .inst_imm_b  (inst_imm_b),
    .take_branch (take_branch),
    .csr_mtvec   (csr_mtvec),
    .trap_int    (trap_int),
    .trap_cause  (trap_cause),
    .csr_mepc    (csr_mepc),
    .mem_dout    (mem_dout),
    .pc_seq_c    (pc_seq_c),
    .target_c    (target_c),
    .redirect_c  (redirect_c),
    .misalign_c  (misalign_c)
  );

  assign pc_seq_out = pc_seq_c;
  assign active_c   = (state_q != PCG_BOOT);
  assign accept_c   = active_c && redirect_c && !misalign_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PCG_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PCG_BOOT: state_d = PCG_RUN;
      PCG_RUN:  if (accept_c && !fetch_ready) state_d = PCG_PEND;
      PCG_PEND: if (fetch_ready) state_d = PCG_RUN;
      default:  state_d = PCG_BOOT;
    endcase
  end

  // PC only moves when the fetch port takes the current address; otherwise redirects park in pend.
  always_comb begin
    pc_d          = pc_out;
    pend_d        = pend_q;
    err_d         = 1'b0;
    addr_d        = misalign_addr;
    fetch_valid_d = (state_d != PCG_BOOT);
    case (state_q)
      PCG_RUN: begin
        if (accept_c) begin
          if (fetch_ready) pc_d = target_c;
          else             pend_d = target_c;
        end else if ((pc_sel_e'(pc_sel) == PC_SEL_SEQ) && fetch_ready) begin
          pc_d = pc_seq_c;
        end
      end
      PCG_PEND: begin
        if (fetch_ready)   pc_d   = accept_c ? target_c : pend_q;
        else if (accept_c) pend_d = target_c;
      end
      default: ;
    endcase
    if (active_c && redirect_c && misalign_c) begin
      err_d  = 1'b1;
      addr_d = target_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out        <= RESET_VEC;
      pend_q        <= '0;
      fetch_valid   <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      pc_out        <= pc_d;
      pend_q        <= pend_d;
      fetch_valid   <= fetch_valid_d;
      misalign_err  <= err_d;
      misalign_addr <= addr_d;
    end
  end

endmodule
